// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared constants for the keypad entry controller: key codes, CPU register map
// and the entry FSM state encoding.
package keypad_entry_ctrl_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] KEY_ENTER     = 4'd10;
    localparam logic [3:0] KEY_BS        = 4'd11;
    localparam logic [3:0] KEY_CLR       = 4'd12;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_ENTRY  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } entry_state_e;

    // A FULL entry reports digit count 0; software infers FULL from a non-zero entry.
    function automatic logic [15:0] status_word(input logic       ovf,
                                                input logic       full,
                                                input logic       empty,
                                                input logic [2:0] fifo_cnt,
                                                input logic [1:0] digits);
        return {8'h00, ovf, full, empty, fifo_cnt, digits};
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// CPU register bus of the keypad entry controller.
// io_rd/io_wr are single-cycle strobes with no back-pressure; read data appears
// on io_rdata after the edge that samples io_rd and holds until the next read.
interface keypad_entry_ctrl_if;

    logic        io_rd;
    logic        io_wr;
    logic [1:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    modport master (output io_rd, io_wr, io_addr, io_wdata, input io_rdata);
    modport slave  (input io_rd, io_wr, io_addr, io_wdata, output io_rdata);

endinterface

// File: rtl/key_fifo.sv
// Committed-entry FIFO. A pop on an empty FIFO is ignored; a push on a full FIFO
// only lands when a pop frees a slot in the same cycle. Flush wins over push.
module key_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             nonempty_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = !nonempty_q;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            nonempty_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            nonempty_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: edge-detects key presses, edits a 4-digit packed-BCD
// entry, commits entries into a FIFO and exposes DATA/STATUS/ENTRY registers.
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           key_code,
    input  logic                 key_pressed,
    keypad_entry_ctrl_if.slave   bus,
    output logic [15:0]          entry_bcd,
    output logic                 data_avail,
    output entry_state_e         dbg_state_o
);

    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] DIG_LAST = 3'(MAX_DIGITS);

    entry_state_e state_q, state_d;
    logic [15:0]  entry_q, entry_d;
    logic [2:0]   dig_q, dig_d;
    logic         key_prev_q;
    logic         key_evt;
    logic [15:0]  rdata_q, rdata_d;
    logic         ovf_q, ovf_d;

    logic          push, pop, flush;
    logic [15:0]   fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    fifo_count_ext;

    // key_prev_q resets high so a key held through reset must be released first.
    assign key_evt        = key_pressed && !key_prev_q;
    assign fifo_count_ext = 5'(fifo_count);

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        dig_d   = dig_q;
        push    = 1'b0;
        if (key_evt) begin
            if (key_code <= KEY_MAX_DIGIT) begin
                if (state_q != ST_FULL) begin
                    entry_d = {entry_q[11:0], key_code};
                    dig_d   = dig_q + 3'd1;
                    state_d = (dig_d == DIG_LAST) ? ST_FULL : ST_ENTRY;
                end
            end else begin
                case (key_code)
                    KEY_BS: begin
                        if (state_q != ST_IDLE) begin
                            entry_d = {4'h0, entry_q[15:4]};
                            dig_d   = dig_q - 3'd1;
                            state_d = (dig_d == 3'd0) ? ST_IDLE : ST_ENTRY;
                        end
                    end
                    KEY_CLR: begin
                        entry_d = '0;
                        dig_d   = '0;
                        state_d = ST_IDLE;
                    end
                    KEY_ENTER: begin
                        push    = (state_q != ST_IDLE);
                        entry_d = '0;
                        dig_d   = '0;
                        state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pop     = 1'b0;
        flush   = 1'b0;
        rdata_d = rdata_q;
        ovf_d   = ovf_q;
        if (bus.io_rd) begin
            case (bus.io_addr)
                ADDR_DATA: begin
                    rdata_d = fifo_empty ? 16'h0000 : fifo_head;
                    pop     = !fifo_empty;
                end
                ADDR_STATUS: rdata_d = status_word(ovf_q, fifo_full, fifo_empty,
                                                   fifo_count_ext[2:0], dig_q[1:0]);
                ADDR_ENTRY:  rdata_d = entry_q;
                default:     rdata_d = 16'h0000;
            endcase
        end
        if (bus.io_wr && bus.io_addr == ADDR_STATUS) begin
            if (bus.io_wdata[0]) ovf_d = 1'b0;
            flush = bus.io_wdata[1];
        end
        // A dropped push sets overflow even when software clears it in the same cycle.
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            dig_q      <= '0;
            key_prev_q <= 1'b1;
            rdata_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            dig_q      <= dig_d;
            key_prev_q <= key_pressed;
            rdata_q    <= rdata_d;
            ovf_q      <= ovf_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (entry_q),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign entry_bcd    = entry_q;
    assign data_avail   = !fifo_empty;
    assign bus.io_rdata = rdata_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: key editing, FIFO commit/read, overflow,
// same-cycle push/pop, register map and reset behaviour.
module tb_keypad_entry_ctrl;
    import keypad_entry_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   key_code;
    logic         key_pressed;
    logic [15:0]  entry_bcd;
    logic         data_avail;
    entry_state_e dbg_state;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rd_val;
    logic [15:0] exp_v;

    keypad_entry_ctrl_if bus_if ();

    keypad_entry_ctrl #(
        .FIFO_DEPTH (4),
        .MAX_DIGITS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .bus         (bus_if),
        .entry_bcd   (entry_bcd),
        .data_avail  (data_avail),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_pressed = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input logic [3:0] c);
        key_code = c;
        key_pressed = 1'b1;
        tick();
        key_pressed = 1'b0;
        tick();
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [15:0] d);
        bus_if.io_rd = 1'b1;
        bus_if.io_addr = a;
        tick();
        bus_if.io_rd = 1'b0;
        d = bus_if.io_rdata;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
        bus_if.io_wr = 1'b1;
        bus_if.io_addr = a;
        bus_if.io_wdata = d;
        tick();
        bus_if.io_wr = 1'b0;
        bus_if.io_wdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++; if (entry_bcd !== 16'h0000) begin err_cnt++; $display("FAIL reset_entry: got %h expected %h", entry_bcd, 16'h0000); end
        vec_cnt++; if (data_avail !== 1'b0) begin err_cnt++; $display("FAIL reset_avail: got %b expected 0", data_avail); end
        vec_cnt++; if (bus_if.io_rdata !== 16'h0000) begin err_cnt++; $display("FAIL reset_rdata: got %h expected 0000", bus_if.io_rdata); end
        vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0020) begin err_cnt++; $display("FAIL reset_status: got %h expected 0020", rd_val); end
    endtask

    task automatic test_basic_entry();
        press(4'd1); press(4'd2); press(4'd3);
        vec_cnt++; if (entry_bcd !== 16'h0123) begin err_cnt++; $display("FAIL basic_entry: got %h expected 0123", entry_bcd); end
        vec_cnt++; if (dbg_state !== ST_ENTRY) begin err_cnt++; $display("FAIL basic_state: got %0d expected %0d", dbg_state, ST_ENTRY); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0023) begin err_cnt++; $display("FAIL basic_status3: got %h expected 0023", rd_val); end
        press(KEY_ENTER);
        vec_cnt++; if (entry_bcd !== 16'h0000 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL basic_commit_clear: got %h/%0d expected 0000/%0d", entry_bcd, dbg_state, ST_IDLE); end
        vec_cnt++; if (data_avail !== 1'b1) begin err_cnt++; $display("FAIL basic_avail: got %b expected 1", data_avail); end
        cpu_read(ADDR_DATA, rd_val);
        vec_cnt++; if (rd_val !== 16'h0123) begin err_cnt++; $display("FAIL basic_data: got %h expected 0123", rd_val); end
        vec_cnt++; if (data_avail !== 1'b0) begin err_cnt++; $display("FAIL basic_avail_after_pop: got %b expected 0", data_avail); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0020) begin err_cnt++; $display("FAIL basic_status_empty: got %h expected 0020", rd_val); end
    endtask

    task automatic test_edit();
        for (int i = 1; i <= 5; i++) press(4'(i));
        vec_cnt++; if (entry_bcd !== 16'h1234) begin err_cnt++; $display("FAIL edit_full_entry: got %h expected 1234", entry_bcd); end
        vec_cnt++; if (dbg_state !== ST_FULL) begin err_cnt++; $display("FAIL edit_full_state: got %0d expected %0d", dbg_state, ST_FULL); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0020) begin err_cnt++; $display("FAIL edit_full_status: got %h expected 0020", rd_val); end
        press(KEY_BS);
        vec_cnt++; if (entry_bcd !== 16'h0123 || dbg_state !== ST_ENTRY) begin err_cnt++; $display("FAIL edit_backspace: got %h/%0d expected 0123/%0d", entry_bcd, dbg_state, ST_ENTRY); end
        press(KEY_CLR);
        vec_cnt++; if (entry_bcd !== 16'h0000 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL edit_clear: got %h/%0d expected 0000/%0d", entry_bcd, dbg_state, ST_IDLE); end
        press(KEY_BS);
        vec_cnt++; if (entry_bcd !== 16'h0000 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL edit_bs_idle: got %h/%0d expected 0000/%0d", entry_bcd, dbg_state, ST_IDLE); end
        press(4'd3); press(4'd14); press(4'd15); press(4'd13);
        vec_cnt++; if (entry_bcd !== 16'h0003) begin err_cnt++; $display("FAIL edit_ignored_codes: got %h expected 0003", entry_bcd); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0021) begin err_cnt++; $display("FAIL edit_status1: got %h expected 0021", rd_val); end
        press(KEY_BS);
        vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL edit_bs_to_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
        press(KEY_ENTER);
        vec_cnt++; if (data_avail !== 1'b0) begin err_cnt++; $display("FAIL edit_enter_idle: got %b expected 0", data_avail); end
        cpu_read(ADDR_DATA, rd_val);
        vec_cnt++; if (rd_val !== 16'h0000 || data_avail !== 1'b0) begin err_cnt++; $display("FAIL edit_read_empty: got %h/%b expected 0000/0", rd_val, data_avail); end
        press(4'd0);
        vec_cnt++; if (dbg_state !== ST_ENTRY) begin err_cnt++; $display("FAIL edit_zero_digit: got %0d expected %0d", dbg_state, ST_ENTRY); end
        press(KEY_ENTER);
        vec_cnt++; if (data_avail !== 1'b1) begin err_cnt++; $display("FAIL edit_zero_commit: got %b expected 1", data_avail); end
        cpu_read(ADDR_DATA, rd_val);
        vec_cnt++; if (rd_val !== 16'h0000 || data_avail !== 1'b0) begin err_cnt++; $display("FAIL edit_zero_read: got %h/%b expected 0000/0", rd_val, data_avail); end
    endtask

    task automatic test_hold();
        key_code = 4'd7;
        key_pressed = 1'b1;
        repeat (1000) tick();
        key_pressed = 1'b0;
        tick();
        vec_cnt++; if (entry_bcd !== 16'h0007) begin err_cnt++; $display("FAIL hold_entry: got %h expected 0007", entry_bcd); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0021) begin err_cnt++; $display("FAIL hold_status: got %h expected 0021", rd_val); end
        press(KEY_CLR);
    endtask

    task automatic test_overflow();
        logic [3:0] d;
        for (int i = 1; i <= 5; i++) begin
            d = 4'(i);
            press(d); press(d); press(KEY_ENTER);
            if (i <= 4) exp_q.push_back({8'h00, d, d});
        end
        vec_cnt++; if (entry_bcd !== 16'h0000) begin err_cnt++; $display("FAIL ovf_entry_cleared: got %h expected 0000", entry_bcd); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h00D0) begin err_cnt++; $display("FAIL ovf_status: got %h expected 00d0", rd_val); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(ADDR_DATA, rd_val);
            exp_v = exp_q.pop_front();
            vec_cnt++; if (rd_val !== exp_v) begin err_cnt++; $display("FAIL ovf_data%0d: got %h expected %h", i, rd_val, exp_v); end
        end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h00A0) begin err_cnt++; $display("FAIL ovf_status_drained: got %h expected 00a0", rd_val); end
        cpu_write(ADDR_STATUS, 16'h0001);
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0020) begin err_cnt++; $display("FAIL ovf_clear: got %h expected 0020", rd_val); end
        for (int i = 1; i <= 4; i++) begin press(4'(i)); press(KEY_ENTER); end
        press(4'd8);
        bus_if.io_wr = 1'b1; bus_if.io_addr = ADDR_STATUS; bus_if.io_wdata = 16'h0001;
        key_code = KEY_ENTER; key_pressed = 1'b1;
        tick();
        bus_if.io_wr = 1'b0; bus_if.io_wdata = '0; key_pressed = 1'b0;
        tick();
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h00D0) begin err_cnt++; $display("FAIL ovf_clear_vs_set: got %h expected 00d0", rd_val); end
        cpu_write(ADDR_STATUS, 16'h0003);
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0020 || data_avail !== 1'b0) begin err_cnt++; $display("FAIL ovf_flush_clear: got %h/%b expected 0020/0", rd_val, data_avail); end
    endtask

    task automatic test_same_cycle();
        for (int i = 1; i <= 4; i++) begin
            press(4'(i)); press(KEY_ENTER);
            exp_q.push_back(16'(i));
        end
        press(4'd5);
        bus_if.io_rd = 1'b1; bus_if.io_addr = ADDR_DATA;
        key_code = KEY_ENTER; key_pressed = 1'b1;
        tick();
        bus_if.io_rd = 1'b0; key_pressed = 1'b0;
        exp_v = exp_q.pop_front();
        exp_q.push_back(16'h0005);
        vec_cnt++; if (bus_if.io_rdata !== exp_v) begin err_cnt++; $display("FAIL pushpop_full_data: got %h expected %h", bus_if.io_rdata, exp_v); end
        tick();
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0050) begin err_cnt++; $display("FAIL pushpop_full_status: got %h expected 0050", rd_val); end
        while (exp_q.size() > 0) begin
            cpu_read(ADDR_DATA, rd_val);
            exp_v = exp_q.pop_front();
            vec_cnt++; if (rd_val !== exp_v) begin err_cnt++; $display("FAIL pushpop_drain: got %h expected %h", rd_val, exp_v); end
        end
        press(4'd7);
        bus_if.io_rd = 1'b1; bus_if.io_addr = ADDR_DATA;
        key_code = KEY_ENTER; key_pressed = 1'b1;
        tick();
        bus_if.io_rd = 1'b0; key_pressed = 1'b0;
        vec_cnt++; if (bus_if.io_rdata !== 16'h0000 || data_avail !== 1'b1) begin err_cnt++; $display("FAIL pushpop_empty: got %h/%b expected 0000/1", bus_if.io_rdata, data_avail); end
        tick();
        cpu_read(ADDR_DATA, rd_val);
        vec_cnt++; if (rd_val !== 16'h0007) begin err_cnt++; $display("FAIL pushpop_empty_data: got %h expected 0007", rd_val); end
    endtask

    task automatic test_regs();
        press(4'd9);
        cpu_read(ADDR_ENTRY, rd_val);
        vec_cnt++; if (rd_val !== 16'h0009) begin err_cnt++; $display("FAIL regs_entry: got %h expected 0009", rd_val); end
        cpu_read(2'd3, rd_val);
        vec_cnt++; if (rd_val !== 16'h0000) begin err_cnt++; $display("FAIL regs_addr3: got %h expected 0000", rd_val); end
        press(KEY_CLR);
        press(4'd2); press(KEY_ENTER);
        press(4'd3); press(KEY_ENTER);
        cpu_write(ADDR_DATA, 16'hFFFF);
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0008) begin err_cnt++; $display("FAIL regs_status_cnt2: got %h expected 0008", rd_val); end
        cpu_write(ADDR_STATUS, 16'h0002);
        vec_cnt++; if (data_avail !== 1'b0) begin err_cnt++; $display("FAIL regs_flush_avail: got %b expected 0", data_avail); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0020) begin err_cnt++; $display("FAIL regs_flush_status: got %h expected 0020", rd_val); end
    endtask

    task automatic test_reset_mid();
        press(4'd1); press(KEY_ENTER);
        press(4'd4); press(4'd5);
        cpu_read(ADDR_ENTRY, rd_val);
        key_code = 4'd8;
        key_pressed = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        vec_cnt++; if (entry_bcd !== 16'h0000 || data_avail !== 1'b0) begin err_cnt++; $display("FAIL rstmid_state: got %h/%b expected 0000/0", entry_bcd, data_avail); end
        vec_cnt++; if (bus_if.io_rdata !== 16'h0000 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rstmid_rdata_fsm: got %h/%0d expected 0000/%0d", bus_if.io_rdata, dbg_state, ST_IDLE); end
        rst = 1'b0;
        repeat (5) tick();
        vec_cnt++; if (entry_bcd !== 16'h0000 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rstmid_held_key: got %h/%0d expected 0000/%0d", entry_bcd, dbg_state, ST_IDLE); end
        key_pressed = 1'b0;
        tick();
        press(4'd6);
        vec_cnt++; if (entry_bcd !== 16'h0006) begin err_cnt++; $display("FAIL rstmid_repress: got %h expected 0006", entry_bcd); end
        cpu_read(ADDR_STATUS, rd_val);
        vec_cnt++; if (rd_val !== 16'h0021) begin err_cnt++; $display("FAIL rstmid_status: got %h expected 0021", rd_val); end
    endtask

    initial begin
        rst = 1'b1;
        key_code = 4'd0;
        key_pressed = 1'b0;
        bus_if.io_rd = 1'b0;
        bus_if.io_wr = 1'b0;
        bus_if.io_addr = 2'd0;
        bus_if.io_wdata = 16'h0000;
        test_reset();
        test_basic_entry();
        test_edit();
        test_hold();
        test_overflow();
        test_same_cycle();
        test_regs();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
